// File: rtl/dcache_tagv_mway_if.sv
// Lookup / fill / flush bus between a cache controller and the tag-valid array.
// Latency: wires only; the array registers its lookup results.
// Backpressure: none on the bus; the array drops requests while it is flushing.
interface dcache_tagv_mway_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int TAG_WIDTH  = 25,
    parameter int WAY        = 2
);
    // lookup request and registered result
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [TAG_WIDTH-1:0]  rd_tag;
    logic                  rd_ack;
    logic [WAY-1:0]        hit;
    logic                  hit_any;
    logic [WAY-1:0]        victim;
    logic                  multi_hit;

    // tag / valid write
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WAY-1:0]        wr_way;
    logic [TAG_WIDTH-1:0]  wr_tag;
    logic                  wr_valid;

    // invalidate-all
    logic                  flush_req;
    logic                  flush_busy;
    logic                  flush_done;

    modport master (
        output rd_en, rd_addr, rd_tag,
        output wr_en, wr_addr, wr_way, wr_tag, wr_valid,
        output flush_req,
        input  rd_ack, hit, hit_any, victim, multi_hit,
        input  flush_busy, flush_done
    );

    modport slave (
        input  rd_en, rd_addr, rd_tag,
        input  wr_en, wr_addr, wr_way, wr_tag, wr_valid,
        input  flush_req,
        output rd_ack, hit, hit_any, victim, multi_hit,
        output flush_busy, flush_done
    );
endinterface

// File: rtl/dcache_tagv_mway.sv
// Set-associative tag/valid array with hit detect, victim pick and invalidate-all sweep.
// Latency: lookup result registered, one cycle; flush sweep one set per cycle.
// Backpressure: none; lookups, writes and new flush pulses are dropped while flush_busy.
module dcache_tagv_mway #(
    parameter int ADDR_WIDTH = 4,
    parameter int TAG_WIDTH  = 25,
    parameter int WAY        = 2
) (
    input  logic               clk,
    input  logic               rst,
    dcache_tagv_mway_if.slave  cache_if
);
    localparam int SETS = 1 << ADDR_WIDTH;
    // keep rr at least one bit wide so a direct-mapped build still elaborates
    localparam int RR_W = (WAY > 1) ? $clog2(WAY) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [RR_W-1:0]       rr_q, rr_d;

    logic [SETS-1:0]       valid_q [WAY];
    logic [TAG_WIDTH-1:0]  tag_q   [WAY][SETS];

    logic                  rd_ack_q;
    logic [WAY-1:0]        hit_q, victim_q;
    logic                  multi_q;

    logic                  busy, sweep_last, rd_go, wr_go;
    logic [WAY-1:0]        look_vld, hit_d, victim_d;
    logic [TAG_WIDTH-1:0]  look_tag [WAY];
    logic                  multi_d, all_vld, found;
    logic [3:0]            hit_cnt;

    assign busy       = (state_q == SWEEP);
    assign sweep_last = busy && (cnt_q == ADDR_WIDTH'(SETS - 1));
    // a flush pulse wins over a lookup or write arriving in the same cycle
    assign rd_go = cache_if.rd_en && !busy && !cache_if.flush_req;
    assign wr_go = cache_if.wr_en && !busy && !cache_if.flush_req;

    // flush FSM next state: start on a pulse in IDLE, walk every set once in SWEEP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cache_if.flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (sweep_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // lookup: read the set, overlay a same-cycle write to the same set, then compare
    always_comb begin
        hit_cnt  = '0;
        victim_d = '0;
        found    = 1'b0;
        for (int i = 0; i < WAY; i++) begin
            look_vld[i] = valid_q[i][cache_if.rd_addr];
            look_tag[i] = tag_q[i][cache_if.rd_addr];
            if (wr_go && (cache_if.wr_addr == cache_if.rd_addr) && cache_if.wr_way[i]) begin
                look_vld[i] = cache_if.wr_valid;
                look_tag[i] = cache_if.wr_tag;
            end
            hit_d[i] = look_vld[i] && (look_tag[i] == cache_if.rd_tag);
            hit_cnt  = hit_cnt + 4'(hit_d[i]);
        end
        multi_d = (hit_cnt >= 4'd2);
        all_vld = &look_vld;
        // lowest invalid way first; round robin only once the set is full
        for (int i = 0; i < WAY; i++) begin
            if (!look_vld[i] && !found) begin
                victim_d[i] = 1'b1;
                found       = 1'b1;
            end
        end
        if (all_vld) begin
            victim_d = WAY'(1) << rr_q;
        end
        rr_d = rr_q;
        if (rd_go && !(|hit_d) && all_vld) begin
            rr_d = (rr_q == RR_W'(WAY - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    // control state and registered lookup result; result holds when no lookup is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_q     <= '0;
            rd_ack_q <= 1'b0;
            hit_q    <= '0;
            victim_q <= '0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            rd_ack_q <= rd_go;
            if (rd_go) begin
                hit_q    <= hit_d;
                victim_q <= victim_d;
                multi_q  <= multi_d;
            end
        end
    end

    // valid bits: sweep clear has the array to itself, otherwise apply writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WAY; i++) valid_q[i] <= '0;
        end else if (busy) begin
            for (int i = 0; i < WAY; i++) valid_q[i][cnt_q] <= 1'b0;
        end else if (wr_go) begin
            for (int i = 0; i < WAY; i++) begin
                if (cache_if.wr_way[i]) valid_q[i][cache_if.wr_addr] <= cache_if.wr_valid;
            end
        end
    end

    // tag storage carries no reset; a tag only matters under its valid bit
    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < WAY; i++) begin
                if (cache_if.wr_way[i]) tag_q[i][cache_if.wr_addr] <= cache_if.wr_tag;
            end
        end
    end

    assign cache_if.rd_ack     = rd_ack_q;
    assign cache_if.hit        = hit_q;
    assign cache_if.hit_any    = |hit_q;
    assign cache_if.victim     = victim_q;
    assign cache_if.multi_hit  = multi_q;
    assign cache_if.flush_busy = busy;
    assign cache_if.flush_done = sweep_last;
endmodule

// File: tb/tb_dcache_tagv_mway.sv
// Directed bench for the tag/valid array: vector table plus flush and reset-mid-flush sequences.
// Latency: results sampled 1 ns after the edge that takes the request.
// Backpressure: none; the bench checks that requests are dropped during a flush.
module tb_dcache_tagv_mway;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dcache_tagv_mway_if #(.ADDR_WIDTH(4), .TAG_WIDTH(25), .WAY(2)) dif ();

    dcache_tagv_mway #(.ADDR_WIDTH(4), .TAG_WIDTH(25), .WAY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .cache_if (dif)
    );

    typedef struct {
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic [24:0] rd_tag;
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [1:0]  wr_way;
        logic [24:0] wr_tag;
        logic        wr_valid;
        logic        e_ack;
        logic [1:0]  e_hit;
        logic [1:0]  e_vic;
        logic        e_multi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic re, input logic [3:0] ra, input logic [24:0] rt,
                                input logic we, input logic [3:0] wa, input logic [1:0] ww,
                                input logic [24:0] wt, input logic wv,
                                input logic ea, input logic [1:0] eh, input logic [1:0] ev,
                                input logic em);
        vec_t v;
        v.rd_en = re; v.rd_addr = ra; v.rd_tag = rt;
        v.wr_en = we; v.wr_addr = wa; v.wr_way = ww; v.wr_tag = wt; v.wr_valid = wv;
        v.e_ack = ea; v.e_hit = eh; v.e_vic = ev; v.e_multi = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic re, input logic [3:0] ra, input logic [24:0] rt,
                         input logic we, input logic [3:0] wa, input logic [1:0] ww,
                         input logic [24:0] wt, input logic wv, input logic fr);
        dif.rd_en = re; dif.rd_addr = ra; dif.rd_tag = rt;
        dif.wr_en = we; dif.wr_addr = wa; dif.wr_way = ww; dif.wr_tag = wt;
        dif.wr_valid = wv; dif.flush_req = fr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 25'd0, 1'b0, 4'd0, 2'b00, 25'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_result(input string nm, input logic ea, input logic [1:0] eh,
                              input logic [1:0] ev, input logic em);
        chk({nm, "_ack"},    32'(dif.rd_ack),    32'(ea));
        chk({nm, "_hit"},    32'(dif.hit),       32'(eh));
        chk({nm, "_hitany"}, 32'(dif.hit_any),   32'(|eh));
        chk({nm, "_victim"}, 32'(dif.victim),    32'(ev));
        chk({nm, "_multi"},  32'(dif.multi_hit), 32'(em));
    endtask

    initial begin
        idle();
        //            rd  ra     rt            wr  wa     ww     wt            wv    ack  hit    vic    multi
        vecs.push_back(mk(1, 4'd3, 25'h1ABCDE, 0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b01, 0)); // cold miss
        vecs.push_back(mk(0, 4'd0, 25'h0,      1, 4'd3, 2'b10, 25'h1ABCDE, 1,    0, 2'b00, 2'b01, 0)); // fill, outputs hold
        vecs.push_back(mk(1, 4'd3, 25'h1ABCDE, 0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b10, 2'b01, 0)); // hit way1
        vecs.push_back(mk(1, 4'd3, 25'h1,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b01, 0)); // miss, way0 free
        vecs.push_back(mk(1, 4'd5, 25'h7,      1, 4'd5, 2'b01, 25'h7,      1,    1, 2'b01, 2'b10, 0)); // bypass
        vecs.push_back(mk(0, 4'd0, 25'h0,      1, 4'd7, 2'b11, 25'h5,      1,    0, 2'b01, 2'b10, 0)); // dual write
        vecs.push_back(mk(1, 4'd7, 25'h5,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b11, 2'b01, 1)); // multi hit
        vecs.push_back(mk(0, 4'd0, 25'h0,      1, 4'd2, 2'b01, 25'hA,      1,    0, 2'b11, 2'b01, 1));
        vecs.push_back(mk(0, 4'd0, 25'h0,      1, 4'd2, 2'b10, 25'hB,      1,    0, 2'b11, 2'b01, 1));
        vecs.push_back(mk(1, 4'd2, 25'hC,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b01, 0)); // rr 0 -> 1
        vecs.push_back(mk(1, 4'd2, 25'hC,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b10, 0)); // rr 1 -> 0
        vecs.push_back(mk(1, 4'd2, 25'hC,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b01, 0)); // rr 0 -> 1
        vecs.push_back(mk(1, 4'd2, 25'hA,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b01, 2'b10, 0)); // hit, rr stays 1
        vecs.push_back(mk(0, 4'd0, 25'h0,      1, 4'd2, 2'b01, 25'h0,      0,    0, 2'b01, 2'b10, 0)); // invalidate way0
        vecs.push_back(mk(1, 4'd2, 25'hA,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b01, 0));
        vecs.push_back(mk(0, 4'd0, 25'h0,      1, 4'd4, 2'b00, 25'h9,      1,    0, 2'b00, 2'b01, 0)); // no-way write
        vecs.push_back(mk(1, 4'd4, 25'h9,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b01, 0));
        vecs.push_back(mk(1, 4'd5, 25'h7,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b01, 2'b10, 0));
        vecs.push_back(mk(1, 4'd5, 25'h6,      0, 4'd0, 2'b00, 25'h0,      0,    1, 2'b00, 2'b10, 0));
        vecs.push_back(mk(1, 4'd7, 25'h5,      1, 4'd7, 2'b10, 25'h5,      0,    1, 2'b01, 2'b10, 0)); // bypass invalidate
        vecs.push_back(mk(1, 4'd3, 25'h1ABCDE, 1, 4'd8, 2'b01, 25'h1ABCDE, 1,    1, 2'b10, 2'b01, 0)); // other-set write

        // reset state
        cyc();
        chk_result("rst", 1'b0, 2'b00, 2'b00, 1'b0);
        chk("rst_busy", 32'(dif.flush_busy), 32'd0);
        chk("rst_done", 32'(dif.flush_done), 32'd0);
        rst = 1'b0;
        cyc();

        foreach (vecs[i]) begin
            drive(vecs[i].rd_en, vecs[i].rd_addr, vecs[i].rd_tag, vecs[i].wr_en, vecs[i].wr_addr,
                  vecs[i].wr_way, vecs[i].wr_tag, vecs[i].wr_valid, 1'b0);
            cyc();
            chk_result($sformatf("v%0d", i), vecs[i].e_ack, vecs[i].e_hit, vecs[i].e_vic, vecs[i].e_multi);
        end
        idle();
        cyc();

        // flush: fill sets 0 and 15, then sweep with lookups held high throughout
        drive(0, 4'd0, 25'h0, 1, 4'd0, 2'b01, 25'h11, 1, 0);  cyc();
        drive(0, 4'd0, 25'h0, 1, 4'd15, 2'b10, 25'h22, 1, 0); cyc();
        drive(1, 4'd0, 25'h11, 0, 4'd0, 2'b00, 25'h0, 0, 0);  cyc();
        chk_result("pre0", 1'b1, 2'b01, 2'b10, 1'b0);
        drive(1, 4'd15, 25'h22, 0, 4'd0, 2'b00, 25'h0, 0, 0); cyc();
        chk_result("pre15", 1'b1, 2'b10, 2'b01, 1'b0);
        drive(1, 4'd0, 25'h11, 1, 4'd1, 2'b01, 25'h33, 1, 1); cyc();
        chk("fl_start_ack", 32'(dif.rd_ack), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("fl%0d_busy", k), 32'(dif.flush_busy), 32'd1);
            chk($sformatf("fl%0d_done", k), 32'(dif.flush_done), 32'(k == 16));
            chk($sformatf("fl%0d_ack", k),  32'(dif.rd_ack),     32'd0);
            drive(1, 4'd0, 25'h11, 1, 4'd0, 2'b01, 25'h11, 1, (k == 5));
            cyc();
        end
        chk("fl_end_busy", 32'(dif.flush_busy), 32'd0);
        chk("fl_end_done", 32'(dif.flush_done), 32'd0);
        chk("fl_end_ack",  32'(dif.rd_ack),     32'd0);
        drive(1, 4'd0, 25'h11, 0, 4'd0, 2'b00, 25'h0, 0, 0);  cyc();
        chk_result("post0", 1'b1, 2'b00, 2'b01, 1'b0);
        drive(1, 4'd15, 25'h22, 0, 4'd0, 2'b00, 25'h0, 0, 0); cyc();
        chk_result("post15", 1'b1, 2'b00, 2'b01, 1'b0);
        drive(1, 4'd1, 25'h33, 0, 4'd0, 2'b00, 25'h0, 0, 0);  cyc();
        chk_result("post1", 1'b1, 2'b00, 2'b01, 1'b0);

        // reset mid-flush: set 9 is beyond the sweep point when reset hits
        drive(0, 4'd0, 25'h0, 1, 4'd9, 2'b01, 25'h44, 1, 0); cyc();
        drive(0, 4'd0, 25'h0, 0, 4'd0, 2'b00, 25'h0, 0, 1);  cyc();
        idle();
        for (int k = 1; k < 6; k++) cyc();
        chk("rm_busy_before", 32'(dif.flush_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_busy", 32'(dif.flush_busy), 32'd0);
        chk("rm_done", 32'(dif.flush_done), 32'd0);
        chk_result("rm", 1'b0, 2'b00, 2'b00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk($sformatf("rm_hold%0d_done", k), 32'(dif.flush_done), 32'd0);
        end
        rst = 1'b0;
        for (int s = 0; s < 16; s++) begin
            drive(1, 4'(s), 25'h44, 0, 4'd0, 2'b00, 25'h0, 0, 0);
            cyc();
            chk_result($sformatf("rm_set%0d", s), 1'b1, 2'b00, 2'b01, 1'b0);
            chk($sformatf("rm_set%0d_done", s), 32'(dif.flush_done), 32'd0);
            chk($sformatf("rm_set%0d_busy", s), 32'(dif.flush_busy), 32'd0);
        end
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
